// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } sw_state_t;

  localparam int SEC_ONES_MAX = 9;
  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_ONES_MAX = 9;
  localparam int MIN_TENS_MAX = 5;

  function automatic int presc_width(input int div);
    return $clog2(div);
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Button inputs, BCD digit outputs and FSM debug state of the stopwatch core.
interface stopwatch_counter_if;
  import stopwatch_pkg::*;

  logic      btn_ss;
  logic      btn_clr;
  logic [3:0] bcd0;
  logic [3:0] bcd1;
  logic [3:0] bcd2;
  logic [3:0] bcd3;
  logic      running;
  logic      wrap;
  sw_state_t state;

  modport master (
    output btn_ss, btn_clr,
    input  bcd0, bcd1, bcd2, bcd3, running, wrap, state
  );

  modport slave (
    input  btn_ss, btn_clr,
    output bcd0, bcd1, bcd2, bcd3, running, wrap, state
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit that counts 0..MAX on inc and reports a carry on its wrap.
module bcd_digit_counter #(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    localparam logic [3:0] MAX_Q = 4'(MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (inc) begin
            q <= (q == MAX_Q) ? 4'd0 : q + 4'd1;
        end
    end

    assign carry = inc & (q == MAX_Q);

endmodule

// File: rtl/stopwatch_counter.sv
// Run/pause/idle stopwatch: button edge detect, 1 Hz prescaler and a
// cascaded MM:SS BCD counter.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV = 40_000_000
) (
    input logic               clk,
    input logic               rst,
    stopwatch_counter_if.slave sw
);

    localparam int             PW        = presc_width(CLK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);

    logic          btn_ss_d;
    logic          btn_clr_d;
    logic          ss_rise;
    logic          clr_rise;
    sw_state_t     state;
    sw_state_t     state_next;
    logic [PW-1:0] presc;
    logic          tick;
    logic          clr_digits;
    logic          c0, c1, c2, c3;
    logic          wrap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_ss_d  <= 1'b0;
            btn_clr_d <= 1'b0;
        end else begin
            btn_ss_d  <= sw.btn_ss;
            btn_clr_d <= sw.btn_clr;
        end
    end

    assign ss_rise  = sw.btn_ss & ~btn_ss_d;
    assign clr_rise = sw.btn_clr & ~btn_clr_d;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // In PAUSE a clear beats start/stop; in RUN a clear is simply dropped.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (ss_rise) state_next = S_RUN;
            S_RUN:   if (ss_rise) state_next = S_PAUSE;
            S_PAUSE: begin
                if (clr_rise)     state_next = S_IDLE;
                else if (ss_rise) state_next = S_RUN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign tick       = (state == S_RUN) && (presc == PRESC_MAX);
    assign clr_digits = (state != S_IDLE) && (state_next == S_IDLE);

    // Held in PAUSE so a partial second survives; zeroed on the way into IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (state == S_RUN) begin
            presc <= tick ? '0 : presc + PW'(1);
        end else if (state_next == S_IDLE) begin
            presc <= '0;
        end
    end

    bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .clr(clr_digits), .inc(tick), .q(sw.bcd0), .carry(c0)
    );
    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .clr(clr_digits), .inc(c0), .q(sw.bcd1), .carry(c1)
    );
    bcd_digit_counter #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .clr(clr_digits), .inc(c1), .q(sw.bcd2), .carry(c2)
    );
    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .clr(clr_digits), .inc(c2), .q(sw.bcd3), .carry(c3)
    );

    // Carry out of the minutes-tens digit is the 59:59 -> 00:00 rollover.
    always_ff @(posedge clk) begin
        if (rst) wrap_q <= 1'b0;
        else     wrap_q <= c3;
    end

    assign sw.wrap    = wrap_q;
    assign sw.running = (state == S_RUN);
    assign sw.state   = state;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with CLK_DIV = 4.
module tb_stopwatch_counter;

  localparam int W = 20;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  logic clk = 1'b0;
  logic rst;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  stopwatch_counter_if sw_if();

  stopwatch_counter #(.CLK_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw_if)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_ss();
    sw_if.btn_ss = 1'b1;
    step(1);
    sw_if.btn_ss = 1'b0;
  endtask

  task automatic press_clr();
    sw_if.btn_clr = 1'b1;
    step(1);
    sw_if.btn_clr = 1'b0;
  endtask

  task automatic press_both();
    sw_if.btn_ss  = 1'b1;
    sw_if.btn_clr = 1'b1;
    step(1);
    sw_if.btn_ss  = 1'b0;
    sw_if.btn_clr = 1'b0;
  endtask

  // expected packing: {state, running, wrap, bcd3, bcd2, bcd1, bcd0}
  task automatic chk(input string nm, input logic [1:0] st, input logic [15:0] digits,
                     input logic wr);
    exp_q.push_back({st, (st == ST_RUN), wr, digits});
    name_q.push_back(nm);
  endtask

  // scoreboard monitor: compares on the falling edge
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {2'(sw_if.state), sw_if.running, sw_if.wrap,
            sw_if.bcd3, sw_if.bcd2, sw_if.bcd1, sw_if.bcd0};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got state=%0d run=%b wrap=%b %h, expected state=%0d run=%b wrap=%b %h",
                 nm, a[19:18], a[17], a[16], a[15:0], e[19:18], e[17], e[16], e[15:0]);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    sw_if.btn_ss  = 1'b0;
    sw_if.btn_clr = 1'b0;
    step(2);
    chk("reset", ST_IDLE, 16'h0000, 1'b0);
    rst = 1'b0;

    // start from IDLE; first tick exactly 4 edges later
    press_ss();  chk("ss_start",   ST_RUN, 16'h0000, 1'b0);
    step(3);     chk("pre_tick",   ST_RUN, 16'h0000, 1'b0);
    step(1);     chk("first_tick", ST_RUN, 16'h0001, 1'b0);
    step(32);    chk("at_0009",    ST_RUN, 16'h0009, 1'b0);
    step(4);     chk("at_0010",    ST_RUN, 16'h0010, 1'b0);
    step(196);   chk("at_0059",    ST_RUN, 16'h0059, 1'b0);
    step(4);     chk("at_0100",    ST_RUN, 16'h0100, 1'b0);
    step(14156); chk("at_5959",    ST_RUN, 16'h5959, 1'b0);
    step(3);     chk("hold_5959",  ST_RUN, 16'h5959, 1'b0);
    step(1);     chk("rollover",   ST_RUN, 16'h0000, 1'b1);
    step(1);     chk("wrap_drop",  ST_RUN, 16'h0000, 1'b0);

    // pause with the prescaler at 2, then resume
    press_ss();  chk("pause",      ST_PAUSE, 16'h0000, 1'b0);
    step(100);   chk("pause_hold", ST_PAUSE, 16'h0000, 1'b0);
    press_ss();  chk("resume",     ST_RUN,   16'h0000, 1'b0);
    step(1);     chk("resume_p1",  ST_RUN,   16'h0000, 1'b0);
    step(1);     chk("resume_p2",  ST_RUN,   16'h0001, 1'b0);

    // clear ignored in RUN, honoured in PAUSE, harmless in IDLE
    step(16);    chk("at_0005",    ST_RUN,   16'h0005, 1'b0);
    press_clr(); chk("clr_in_run", ST_RUN,   16'h0005, 1'b0);
    press_ss();  chk("pause2",     ST_PAUSE, 16'h0005, 1'b0);
    press_clr(); chk("clr_pause",  ST_IDLE,  16'h0000, 1'b0);
    step(1);
    press_clr(); chk("clr_idle",   ST_IDLE,  16'h0000, 1'b0);
    step(10);    chk("idle_hold",  ST_IDLE,  16'h0000, 1'b0);

    // prescaler must restart from zero after a clear
    press_ss();  chk("restart",      ST_RUN, 16'h0000, 1'b0);
    step(3);     chk("restart_pre",  ST_RUN, 16'h0000, 1'b0);
    step(1);     chk("restart_tick", ST_RUN, 16'h0001, 1'b0);

    // simultaneous events
    press_ss();  chk("pause3",       ST_PAUSE, 16'h0001, 1'b0);
    step(1);
    press_both(); chk("both_pause",  ST_IDLE,  16'h0000, 1'b0);
    step(1);
    press_ss();  chk("run3",         ST_RUN,   16'h0000, 1'b0);
    step(8);     chk("at_0002",      ST_RUN,   16'h0002, 1'b0);
    press_both(); chk("both_run",    ST_PAUSE, 16'h0002, 1'b0);
    step(20);    chk("both_run_hold", ST_PAUSE, 16'h0002, 1'b0);
    press_clr(); chk("clr4",         ST_IDLE,  16'h0000, 1'b0);

    // held start/stop gives a single event
    sw_if.btn_ss = 1'b1;
    step(1);     chk("held_start", ST_RUN, 16'h0000, 1'b0);
    step(49);    chk("held_run",   ST_RUN, 16'h0012, 1'b0);
    sw_if.btn_ss = 1'b0;
    step(1);     chk("held_rel",   ST_RUN, 16'h0012, 1'b0);
    step(98);    chk("at_0037",    ST_RUN, 16'h0037, 1'b0);

    // reset mid-run with start/stop held through release
    rst = 1'b1;
    sw_if.btn_ss = 1'b1;
    step(1);     chk("rst_mid",     ST_IDLE, 16'h0000, 1'b0);
    rst = 1'b0;
    step(1);     chk("rst_rel_run", ST_RUN,  16'h0000, 1'b0);
    sw_if.btn_ss = 1'b0;
    step(4);     chk("rst_rel_tick", ST_RUN, 16'h0001, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
